// File: rtl/tg_bus_pkg.sv
// tg_bus_pkg: shared FSM state type, index-width helper and reset constants for tg_bus_arbiter
package tg_bus_pkg;
  typedef enum logic [1:0] {IDLE, GAP, OWN} state_t;
  localparam logic [15:0] GRANT_RST = '0;
  localparam int unsigned PTR_RST = 0;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/tg_rr_pick.sv
// tg_rr_pick: combinational round-robin picker, first unmasked req at or after ptr with wrap
module tg_rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] mask,
  input  logic [W-1:0] ptr,
  output logic         any,
  output logic [W-1:0] winner
);
  logic [N-1:0] el, rot;
  logic [W-1:0] off;
  logic [W:0] sum;
  assign el = req & ~mask;
  assign rot = N'({el, el} >> ptr);
  assign any = |el;
  always_comb begin
    off = '0;
    for (int i = N - 1; i >= 0; i--) if (rot[i]) off = W'(i);
  end
  assign sum = {1'b0, ptr} + {1'b0, off};
  assign winner = sum >= (W + 1)'(N) ? W'(sum - (W + 1)'(N)) : sum[W-1:0];
endmodule

// File: rtl/tg_bus_arbiter.sv
// tg_bus_arbiter: break-before-make round-robin gate-enable arbiter, forced release under TG_TIMEOUT_EN
module tg_bus_arbiter
  import tg_bus_pkg::*;
#(
  parameter int N_SRC = 4,
  parameter int GAP_CYCLES = 1,
  parameter int HOLD_MAX = 8,
  localparam int W = idx_w(N_SRC)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] req,
  output logic [N_SRC-1:0] grant,
  output logic [W-1:0]     grant_id,
  output logic             bus_busy,
  output logic             timeout
);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [W-1:0] LAST = W'(N_SRC - 1);
  state_t state, state_nx;
  logic [W-1:0] ptr, ptr_nx, id_nx, pick_ptr, win, nxt_id;
  logic [N_SRC-1:0] grant_nx, mask_q, mask_pick;
  logic [GW-1:0] gap_cnt, gap_nx;
  logic any, expire, own_rel, load, gap_end;
  assign nxt_id = grant_id == LAST ? '0 : grant_id + W'(1);
  assign own_rel = state == OWN && (!req[grant_id] || expire);
  assign gap_end = state == GAP && gap_cnt == GW'(1);
  assign pick_ptr = state == OWN ? nxt_id : ptr;
  assign mask_pick = mask_q | (expire ? grant : '0);
  tg_rr_pick #(.N(N_SRC), .W(W)) u_pick (
    .req(req),
    .mask(mask_pick),
    .ptr(pick_ptr),
    .any(any),
    .winner(win)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr <= W'(PTR_RST);
      grant_id <= '0;
      grant <= GRANT_RST[N_SRC-1:0];
      gap_cnt <= '0;
    end else begin
      state <= state_nx;
      ptr <= ptr_nx;
      grant_id <= id_nx;
      grant <= grant_nx;
      gap_cnt <= gap_nx;
    end
  end
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (any) state_nx = GAP;
      GAP: if (gap_cnt == GW'(1)) begin
        if (req[grant_id]) state_nx = OWN;
        else state_nx = IDLE;
      end
      OWN: if (own_rel) begin
        if (any) state_nx = GAP;
        else state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    load = (state == IDLE || own_rel) && any;
    id_nx = load ? win : grant_id;
    gap_nx = load ? GW'(GAP_CYCLES) : state == GAP ? gap_cnt - GW'(1) : gap_cnt;
    ptr_nx = own_rel ? nxt_id : ptr;
    grant_nx = gap_end && req[grant_id] ? N_SRC'(1) << grant_id : own_rel ? '0 : grant;
    bus_busy = |grant;
  end
`ifdef TG_TIMEOUT_EN
  localparam int HW = $clog2(HOLD_MAX + 1);
  logic [HW-1:0] hold_cnt;
  assign expire = state == OWN && req[grant_id] && hold_cnt == HW'(HOLD_MAX);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_cnt <= '0;
      mask_q <= '0;
      timeout <= 1'b0;
    end else begin
      hold_cnt <= state_nx == OWN ? hold_cnt + HW'(1) : '0;
      mask_q <= (mask_q & req) | (expire ? grant : '0);
      timeout <= expire;
    end
  end
`else
  assign expire = 1'b0;
  assign mask_q = '0;
  assign timeout = 1'b0;
`endif
endmodule
